pc_branch_unit: RTL

Program-counter and branch-resolution stage of the lab CPU. Holds the 16-bit PC, fetches instruction words from instruction memory over a req/ready handshake, and computes the next PC. The next PC is either sequential or a PC-relative branch target, using the 16-bit sign-extended offset produced by the sign-extension stage. It sits directly downstream of the sign extender and upstream of decode.

---
 rtl/pc_pkg.sv | 23 ++
 rtl/pc_next_calc.sv | 37 +++
 rtl/pc_branch_unit.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// ============================================================================
// Module      : pc_pkg
// Description : Shared types and default constants for the PC/branch stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pc_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        ERR   = 2'd3
    } pc_state_e;

    localparam int          PC_WIDTH_DEF     = 16;
    localparam logic [15:0] RESET_VECTOR_DEF = 16'h0000;
    localparam int          TIMEOUT_DEF      = 15;

endpackage

`default_nettype wire

// File: rtl/pc_next_calc.sv
// ============================================================================
// Module      : pc_next_calc
// Description : Combinational next-PC select: return > taken branch > sequential.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_next_calc
    import pc_pkg::*;
#(
    parameter int PC_WIDTH = PC_WIDTH_DEF
) (
    input  logic [PC_WIDTH-1:0] pc_i,
    input  logic [PC_WIDTH-1:0] offset_i,
    input  logic                branch_taken_i,
    input  logic                ret_en_i,
    input  logic [PC_WIDTH-1:0] link_i,
    output logic [PC_WIDTH-1:0] next_pc_o
);

    logic [PC_WIDTH-1:0] w_seq_pc;

    // All arithmetic wraps modulo 2^PC_WIDTH; carries are dropped.
    assign w_seq_pc = pc_i + PC_WIDTH'(1);

    always_comb begin
        next_pc_o = w_seq_pc;
        if (ret_en_i) begin
            next_pc_o = link_i;
        end else if (branch_taken_i) begin
            next_pc_o = w_seq_pc + offset_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pc_branch_unit.sv
// ============================================================================
// Module      : pc_branch_unit
// Description : PC register, imem fetch FSM with timeout, branch resolution.
//               Optional call/return link register under PC_LINK_REG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_branch_unit
    import pc_pkg::*;
#(
    parameter int                PC_WIDTH     = PC_WIDTH_DEF,
    parameter int                INSTR_WIDTH  = 16,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = PC_WIDTH'(RESET_VECTOR_DEF),
    parameter int                TIMEOUT      = TIMEOUT_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic                   imem_ready,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic                   instr_valid,
    input  logic                   stall,
    input  logic                   branch_taken,
    input  logic [PC_WIDTH-1:0]    offset,
    input  logic                   call_en,
    input  logic                   ret_en,
    output logic [PC_WIDTH-1:0]    link_out,
    output logic                   fetch_err
);

    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    pc_state_e               state_q, state_d;
    logic [PC_WIDTH-1:0]     pc_q, pc_d;
    logic [INSTR_WIDTH-1:0]  instr_q, instr_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    fetch_err_q, fetch_err_d;

    logic                    w_exec_exit;
    logic                    w_ret;
    logic [PC_WIDTH-1:0]     w_link;
    logic [PC_WIDTH-1:0]     w_next_pc;

    assign w_exec_exit = (state_q == EXEC) && !stall;

`ifdef PC_LINK_REG_EN
    logic [PC_WIDTH-1:0] link_q, link_d;

    // A combined call+ret is treated as a return; the link is left alone.
    always_comb begin
        link_d = link_q;
        if (w_exec_exit && call_en && branch_taken && !ret_en) begin
            link_d = pc_q + PC_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            link_q <= '0;
        end else begin
            link_q <= link_d;
        end
    end

    assign w_ret  = ret_en;
    assign w_link = link_q;
`else
    logic w_unused;
    assign w_unused = &{1'b0, call_en, ret_en};
    assign w_ret    = 1'b0;
    assign w_link   = '0;
`endif

    pc_next_calc #(
        .PC_WIDTH (PC_WIDTH)
    ) u_next_calc (
        .pc_i           (pc_q),
        .offset_i       (offset),
        .branch_taken_i (branch_taken),
        .ret_en_i       (w_ret),
        .link_i         (w_link),
        .next_pc_o      (w_next_pc)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        cnt_d       = cnt_q;
        fetch_err_d = fetch_err_q;
        case (state_q)
            BOOT: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (imem_ready) begin
                    instr_d = imem_rdata;
                    cnt_d   = '0;
                    state_d = EXEC;
                end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    cnt_d       = '0;
                    fetch_err_d = 1'b1;
                    state_d     = ERR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            EXEC: begin
                if (!stall) begin
                    pc_d    = w_next_pc;
                    state_d = FETCH;
                end
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= BOOT;
            pc_q        <= RESET_VECTOR;
            instr_q     <= '0;
            cnt_q       <= '0;
            fetch_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            cnt_q       <= cnt_d;
            fetch_err_q <= fetch_err_d;
        end
    end

    assign imem_req    = (state_q == FETCH);
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_valid = (state_q == EXEC);
    assign fetch_err   = fetch_err_q;
    assign link_out    = w_link;

endmodule

`default_nettype wire
